// File: rtl/ex_memseq.sv
// ex_memseq: memory-access sequencer between EX1 and the L1 data cache.
// Latches one EX1 request, drives it to the cache until OK/FAULT (or a
// bounded HOLD timeout), stalls the pipeline meanwhile, and returns
// sign/zero-extended load data with the held destination ID.
module ex_memseq #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  exOpm,
  input  logic [31:0] exAddr,
  input  logic [63:0] exDataOut,
  input  logic [5:0]  exHeldId,
  input  logic        pipeFlush,
  output logic        exHold,
  output logic [5:0]  exIdRn,
  output logic [63:0] exValRn,
  output logic        exFault,
  output logic [31:0] dcAddr,
  output logic [4:0]  dcOpm,
  output logic [63:0] dcDataOut,
  input  logic [63:0] dcDataIn,
  input  logic [1:0]  dcOk
);

  // "No writeback" register ID and the idle cache opcode.
  localparam logic [5:0] JX2_GR_ZZR     = 6'h3F;
  localparam logic [4:0] UMEM_OPM_READY = 5'b00000;

  localparam logic [1:0] DC_OK    = 2'b01;
  localparam logic [1:0] DC_FAULT = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    FLT  = 2'd3
  } state_t;

  state_t      state;
  logic [4:0]  opmLatch;
  logic [5:0]  idLatch;
  logic [7:0]  tmoCount;
  logic        killBit;

  logic        reqValid;
  logic        canAccept;
  logic        killNow;
  logic        isLoad;
  logic [7:0]  tmoNext;
  logic        tmoHit;

  // Sign- or zero-extend cache load data according to size and opm[2].
  function automatic logic [63:0] extendLoad(input logic [1:0] size,
                                             input logic zext,
                                             input logic [63:0] d);
    logic [63:0] r;
    case (size)
      2'b00:   r = zext ? {56'd0, d[7:0]}  : {{56{d[7]}},  d[7:0]};
      2'b01:   r = zext ? {48'd0, d[15:0]} : {{48{d[15]}}, d[15:0]};
      2'b10:   r = zext ? {32'd0, d[31:0]} : {{32{d[31]}}, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Request qualification, stall request and kill/timeout helpers.
  always_comb begin
    reqValid  = (exOpm[4:3] != 2'b00) && !pipeFlush;
    canAccept = (state == IDLE) || (state == DONE);
    exHold    = (state == REQ) || (canAccept && reqValid);
    // A flush in the same cycle as the cache response still kills it.
    killNow   = killBit || pipeFlush;
    isLoad    = (opmLatch[4:3] == 2'b01);
    tmoNext   = tmoCount + 8'd1;
    tmoHit    = (tmoNext >= TIMEOUT);
  end

  // Sequencer FSM with registered cache-side and writeback outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      opmLatch  <= 5'd0;
      idLatch   <= 6'd0;
      tmoCount  <= 8'd0;
      killBit   <= 1'b0;
      exIdRn    <= JX2_GR_ZZR;
      exValRn   <= 64'd0;
      exFault   <= 1'b0;
      dcAddr    <= 32'd0;
      dcOpm     <= UMEM_OPM_READY;
      dcDataOut <= 64'd0;
    end else begin
      // Writeback and fault are single-cycle presentations.
      exIdRn  <= JX2_GR_ZZR;
      exValRn <= 64'd0;
      exFault <= 1'b0;

      case (state)
        IDLE, DONE: begin
          if (reqValid) begin
            opmLatch  <= exOpm;
            idLatch   <= exHeldId;
            tmoCount  <= 8'd0;
            killBit   <= 1'b0;
            dcOpm     <= exOpm;
            dcAddr    <= exAddr;
            dcDataOut <= exDataOut;
            state     <= REQ;
          end else begin
            dcOpm <= UMEM_OPM_READY;
            state <= IDLE;
          end
        end

        REQ: begin
          killBit <= killNow;
          if (dcOk == DC_OK) begin
            dcOpm <= UMEM_OPM_READY;
            state <= DONE;
            if (isLoad) begin
              exValRn <= extendLoad(opmLatch[1:0], opmLatch[2], dcDataIn);
              if (!killNow) begin
                exIdRn <= idLatch;
              end
            end
          end else if ((dcOk == DC_FAULT) || tmoHit) begin
            // Cache fault and timeout collapse into a single FLT visit.
            dcOpm    <= UMEM_OPM_READY;
            exFault  <= !killNow;
            tmoCount <= tmoNext;
            state    <= FLT;
          end else begin
            tmoCount <= tmoNext;
          end
        end

        default: begin
          dcOpm <= UMEM_OPM_READY;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_memseq.sv
// Directed testbench for ex_memseq (TIMEOUT=4). Inputs are driven and
// outputs sampled 2 time units after each rising clock edge.
module tb_ex_memseq;

  localparam logic [5:0] ZZR   = 6'h3F;
  localparam logic [4:0] READY = 5'b00000;
  localparam logic [1:0] OK_R  = 2'b00;
  localparam logic [1:0] OK_OK = 2'b01;
  localparam logic [1:0] OK_HL = 2'b10;
  localparam logic [1:0] OK_FT = 2'b11;

  logic        clock;
  logic        reset;
  logic [4:0]  exOpm;
  logic [31:0] exAddr;
  logic [63:0] exDataOut;
  logic [5:0]  exHeldId;
  logic        pipeFlush;
  logic        exHold;
  logic [5:0]  exIdRn;
  logic [63:0] exValRn;
  logic        exFault;
  logic [31:0] dcAddr;
  logic [4:0]  dcOpm;
  logic [63:0] dcDataOut;
  logic [63:0] dcDataIn;
  logic [1:0]  dcOk;

  int nCompared = 0;
  int nMismatch = 0;

  ex_memseq #(.TIMEOUT(8'd4)) dut (
    .clock     (clock),
    .reset     (reset),
    .exOpm     (exOpm),
    .exAddr    (exAddr),
    .exDataOut (exDataOut),
    .exHeldId  (exHeldId),
    .pipeFlush (pipeFlush),
    .exHold    (exHold),
    .exIdRn    (exIdRn),
    .exValRn   (exValRn),
    .exFault   (exFault),
    .dcAddr    (dcAddr),
    .dcOpm     (dcOpm),
    .dcDataOut (dcDataOut),
    .dcDataIn  (dcDataIn),
    .dcOk      (dcOk)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatch++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  task automatic idleInputs;
    exOpm = 5'd0; exAddr = 32'd0; exDataOut = 64'd0; exHeldId = 6'd0;
    pipeFlush = 1'b0; dcOk = OK_R; dcDataIn = 64'd0;
  endtask

  task automatic request(input logic [4:0] opm, input logic [31:0] addr,
                         input logic [63:0] data, input logic [5:0] id);
    exOpm = opm; exAddr = addr; exDataOut = data; exHeldId = id;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idleInputs();
    reset = 1'b1;
    tick();
    tick();
    checkVal("rst_hold",  exHold,  1'b0);
    checkVal("rst_fault", exFault, 1'b0);
    checkVal("rst_id",    exIdRn,  ZZR);
    checkVal("rst_val",   exValRn, 64'd0);
    checkVal("rst_opm",   dcOpm,   READY);
    checkVal("rst_addr",  dcAddr,  32'd0);
    checkVal("rst_dout",  dcDataOut, 64'd0);
    reset = 1'b0;
    tick();

    // Quad load, zero wait.
    request(5'b01011, 32'h1000, 64'd0, 6'h05);
    #1 checkVal("q_hold_t0", exHold, 1'b1);
    tick();
    idleInputs();
    dcOk = OK_OK; dcDataIn = 64'h0123_4567_89AB_CDEF;
    #1;
    checkVal("q_hold_t1", exHold, 1'b1);
    checkVal("q_dcopm",   dcOpm,  5'b01011);
    checkVal("q_dcaddr",  dcAddr, 32'h1000);
    tick();
    dcOk = OK_R;
    #1;
    checkVal("q_hold_t2", exHold,  1'b0);
    checkVal("q_id",      exIdRn,  6'h05);
    checkVal("q_val",     exValRn, 64'h0123_4567_89AB_CDEF);
    checkVal("q_dcopm_done", dcOpm, READY);
    tick();
    checkVal("q_id_after", exIdRn, ZZR);

    // Signed byte load with 3 HOLD cycles.
    request(5'b01000, 32'h1004, 64'd0, 6'h0A);
    tick();
    idleInputs();
    dcDataIn = 64'h1234_5678_90AB_CD80;
    dcOk = OK_HL; tick(); tick(); tick();
    dcOk = OK_OK; tick();
    dcOk = OK_R;
    checkVal("sb_id",  exIdRn,  6'h0A);
    checkVal("sb_val", exValRn, 64'hFFFF_FFFF_FFFF_FF80);
    tick();

    // Same with zero extension.
    request(5'b01100, 32'h1004, 64'd0, 6'h0B);
    tick();
    idleInputs();
    dcDataIn = 64'h1234_5678_90AB_CD80;
    dcOk = OK_HL; tick(); tick(); tick();
    dcOk = OK_OK; tick();
    dcOk = OK_R;
    checkVal("zb_id",  exIdRn,  6'h0B);
    checkVal("zb_val", exValRn, 64'h0000_0000_0000_0080);
    tick();

    // Store.
    request(5'b10010, 32'h2000, 64'h0000_0000_DEAD_BEEF, 6'h0C);
    tick();
    idleInputs();
    dcOk = OK_HL;
    #1;
    checkVal("st_dout", dcDataOut, 64'h0000_0000_DEAD_BEEF);
    checkVal("st_opm",  dcOpm,     5'b10010);
    tick();
    dcOk = OK_OK;
    checkVal("st_opm2", dcOpm, 5'b10010);
    tick();
    dcOk = OK_R;
    checkVal("st_id",  exIdRn,  ZZR);
    checkVal("st_val", exValRn, 64'd0);
    checkVal("st_hold", exHold, 1'b0);
    tick();

    // Cache FAULT.
    request(5'b01011, 32'h3000, 64'd0, 6'h0D);
    tick();
    idleInputs();
    dcOk = OK_FT;
    tick();
    dcOk = OK_R;
    checkVal("f_fault", exFault, 1'b1);
    checkVal("f_id",    exIdRn,  ZZR);
    checkVal("f_hold",  exHold,  1'b0);
    checkVal("f_opm",   dcOpm,   READY);
    tick();
    checkVal("f_fault_end", exFault, 1'b0);

    // Timeout with TIMEOUT=4 and constant HOLD.
    request(5'b01011, 32'h3008, 64'd0, 6'h0E);
    tick();
    idleInputs();
    dcOk = OK_HL;
    tick(); tick(); tick();
    checkVal("to_hold4",  exHold,  1'b1);
    checkVal("to_nofault", exFault, 1'b0);
    tick();
    checkVal("to_fault", exFault, 1'b1);
    checkVal("to_hold",  exHold,  1'b0);
    dcOk = OK_R;
    tick();

    // Flush mid-REQ on a load.
    request(5'b01011, 32'h4000, 64'd0, 6'h11);
    tick();
    idleInputs();
    dcOk = OK_HL; pipeFlush = 1'b1;
    tick();
    pipeFlush = 1'b0; dcOk = OK_OK; dcDataIn = 64'h55;
    checkVal("fl_hold_req", exHold, 1'b1);
    tick();
    dcOk = OK_R;
    checkVal("fl_id", exIdRn, ZZR);
    tick();

    // Flush coinciding with OK.
    request(5'b01011, 32'h4008, 64'd0, 6'h12);
    tick();
    idleInputs();
    dcOk = OK_OK; pipeFlush = 1'b1; dcDataIn = 64'h66;
    tick();
    idleInputs();
    checkVal("flok_id", exIdRn, ZZR);
    tick();

    // Flush with a request in IDLE: not accepted.
    request(5'b01011, 32'h4010, 64'd0, 6'h13);
    pipeFlush = 1'b1;
    #1 checkVal("fi_hold", exHold, 1'b0);
    tick();
    checkVal("fi_opm",  dcOpm,  READY);
    checkVal("fi_hold2", exHold, 1'b0);
    idleInputs();
    tick();

    // Asynchronous reset mid-REQ.
    request(5'b01011, 32'h5000, 64'h77, 6'h14);
    tick();
    idleInputs();
    dcOk = OK_HL;
    #1 checkVal("ar_opm_req", dcOpm, 5'b01011);
    reset = 1'b1;
    #1;
    checkVal("ar_opm",  dcOpm,  READY);
    checkVal("ar_addr", dcAddr, 32'd0);
    checkVal("ar_hold", exHold, 1'b0);
    reset = 1'b0;
    dcOk = OK_R;
    tick();
    checkVal("ar_opm_after", dcOpm, READY);

    // Back-to-back loads: second accepted from DONE.
    request(5'b01011, 32'h6000, 64'd0, 6'h07);
    tick();
    idleInputs();
    dcOk = OK_OK; dcDataIn = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();
    request(5'b01001, 32'h6100, 64'd0, 6'h08);
    dcOk = OK_R;
    #1;
    checkVal("bb_id1",  exIdRn,  6'h07);
    checkVal("bb_val1", exValRn, 64'hAAAA_BBBB_CCCC_DDDD);
    checkVal("bb_hold", exHold,  1'b1);
    tick();
    idleInputs();
    dcOk = OK_OK; dcDataIn = 64'h1111_2222_3333_8001;
    #1;
    checkVal("bb_opm2",  dcOpm,  5'b01001);
    checkVal("bb_addr2", dcAddr, 32'h6100);
    tick();
    dcOk = OK_R;
    checkVal("bb_id2",  exIdRn,  6'h08);
    checkVal("bb_val2", exValRn, 64'hFFFF_FFFF_FFFF_8001);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule

// File: doc/ex_memseq.md
# ex_memseq

Memory-access sequencer between the EX1 stage and the L1 data cache. It latches the memory request EX1 raises (opm/address/store data), drives it to the cache until the cache reports OK or FAULT, and holds the pipeline via `exHold` meanwhile. It sign- or zero-extends load data and presents it with the held destination ID for writeback. It also applies a bounded-wait timeout so a hung cache converts into a fault rather than a permanent stall.

## Interface
Parameters:
- `TIMEOUT`, default 8'd255: maximum consecutive cycles of cache HOLD before a fault is forced.

Ports:
- `clock`  in  1  core clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `exOpm`  in  5  EX1 request opm. [4:3]=10 store, 01 load, 00 none. [2]=zero-extend on load. [1:0]=size (00 B, 01 W, 10 L, 11 Q).
- `exAddr`  in  32  EX1 effective address.
- `exDataOut`  in  64  EX1 store data.
- `exHeldId`  in  6  destination GPR ID for loads (EX1 held ID).
- `pipeFlush`  in  1  current EX1 instruction is squashed.
- `exHold`  out  1  stall request to the pipeline.
- `exIdRn`  out  6  writeback destination ID; `JX2_GR_ZZR` when no writeback.
- `exValRn`  out  64  writeback value.
- `exFault`  out  1  one-cycle memory fault strobe.
- `dcAddr`  out  32  cache address.
- `dcOpm`  out  5  cache opm; `UMEM_OPM_READY` when idle.
- `dcDataOut`  out  64  cache store data.
- `dcDataIn`  in  64  cache load data, valid when `dcOk`=OK.
- `dcOk`  in  2  cache status: 00 READY, 01 OK, 10 HOLD, 11 FAULT.

## Operation
- States: IDLE, REQ, DONE, FLT. Reset forces IDLE.
- **Accept.** In IDLE or DONE, a request is accepted when `exOpm[4:3]`!=00 and `pipeFlush`=0.
  - Latch opm, address, store data, `exHeldId`.
  - Clear the timeout counter.
  - Go to REQ.
  - If `pipeFlush`=1, nothing is latched.
- **REQ.** `dcAddr`, `dcOpm` and `dcDataOut` are driven from the latches. Action by `dcOk`:
  - OK: latch the extended load data; go to DONE.
  - FAULT: go to FLT.
  - HOLD or READY: increment the counter; when the counter reaches `TIMEOUT`, go to FLT.
- **Flush while in REQ.** If `pipeFlush` asserts, set a sticky kill bit. The cache transaction still completes, but DONE then performs no writeback.
- **DONE.**
  - Writeback is presented for one cycle: `exIdRn`=latched ID, but only for an unkilled load; otherwise `JX2_GR_ZZR`.
  - `exValRn` = latched value.
  - Next state is REQ if a new request is accepted, else IDLE.
- **FLT.** `exFault`=1 for one cycle (suppressed if killed), no writeback, then IDLE.
- **Load extension** of `dcDataIn`, by size:
  - B: bits [7:0]
  - W: bits [15:0]
  - L: bits [31:0]
  - Q: bits [63:0], passed through
  - Sign-extend from the top selected bit when opm[2]=0; zero-extend when opm[2]=1.
- **Stores.** Write back nothing; `exValRn` is don't-care and is driven 0.

## Timing
- **Reset values:**
  - `exHold`=0, `exFault`=0
  - `exIdRn`=`JX2_GR_ZZR`, `exValRn`=0
  - `dcOpm`=`UMEM_OPM_READY`, `dcAddr`=0, `dcDataOut`=0
  - Counter and kill bit = 0
- **`exHold`** is combinational: 1 when in REQ, or when in IDLE/DONE with an acceptable request present. It is 0 in FLT.
- **Minimum latency**, request cycle t (request seen, `exHold`=1):
  - t+1: REQ drives the cache.
  - If `dcOk`=OK at t+1: t+2 is DONE, `exHold`=0, writeback valid.
  - Load-to-writeback is 2 cycles; each HOLD cycle adds 1.
- **`dcOpm`** is READY in IDLE, DONE and FLT. The cache never sees a request for two consecutive cycles unless back-to-back REQ→DONE→REQ.
- **Timeout:** with `TIMEOUT`=N, FLT is entered on the N-th consecutive non-OK, non-FAULT cycle in REQ.
- **Simultaneous events:**
  - FAULT and counter reaching `TIMEOUT` in the same cycle → single FLT.
  - `pipeFlush` coinciding with OK → kill applies; no writeback.
- **Asynchronous reset mid-REQ:** returns to IDLE immediately and drops `dcOpm` to READY. Cache-side abort is the cache's responsibility.

## Test plan
- **Quad load, 0-wait:**
  - Stimulus: `exOpm`=01011, addr 0x1000, `exHeldId`=6'h05; `dcOk`=OK one cycle after the request.
  - Required: `exHold`=1 for 2 cycles; `exIdRn`=05 and `exValRn`=`dcDataIn` in cycle t+2.
- **Signed byte load with 3 HOLDs:**
  - Stimulus: opm 01000; `dcDataIn`=0x..80.
  - Required: `exValRn`=0xFFFFFFFFFFFFFF80 at t+5.
  - Same stimulus with opm 01100 → `exValRn`=0x80.
- **Store:**
  - Stimulus: opm 10010, data 0xDEADBEEF.
  - Required: `dcDataOut`=0xDEADBEEF and `dcOpm`=10010 while in REQ; `exIdRn`=ZZR in DONE.
- **Fault and timeout:**
  - `dcOk`=FAULT → `exFault` pulses 1 cycle, no writeback.
  - `TIMEOUT`=4 with constant HOLD → FLT after the 4th HOLD cycle.
- **Flush:**
  - Stimulus: `pipeFlush` pulsed mid-REQ on a load.
  - Required: the transaction completes and `exIdRn` stays ZZR.
  - Flush with a request in IDLE → no acceptance and `dcOpm` stays READY.
- **Reset mid-REQ and back-to-back:**
  - Async reset during REQ → all outputs return to reset values before the next edge.
  - Two back-to-back loads → the second enters REQ directly from DONE.
